// File: rtl/pulse_stretcher.sv
// Per-channel pulse stretcher: each accepted one-cycle pulse becomes a HOLD_CYCLES-long high window
// followed by at least GAP_CYCLES low. Define PULSE_STRETCHER_RETRIGGER_EN to extend windows instead.
module pulse_stretcher #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned PEND_MAX    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pulse_in,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] busy,
    output logic [WIDTH-1:0] overflow
);

    localparam int unsigned MaxCnt = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned PendW  = $clog2(PEND_MAX + 1);

    localparam logic [CntW-1:0]  HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0]  GapLoad  = CntW'(GAP_CYCLES - 1);
    localparam logic [PendW-1:0] PendFull = PendW'(PEND_MAX);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_e            state_q, state_d;
        logic [CntW-1:0]   cnt_q, cnt_d;
        logic [PendW-1:0]  pend_q, pend_d;
        logic              ovf_q, ovf_d;
        logic              queue_req;
        logic              take;
        logic              accept;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            pend_d    = pend_q;
            ovf_d     = ovf_q & ~ovf_clr;
            queue_req = 1'b0;
            take      = 1'b0;
            accept    = 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (pulse_in[g]) begin
                        state_d = StHold;
                        cnt_d   = HoldLoad;
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                    if (pulse_in[g]) begin
                        state_d = StHold;
                        cnt_d   = HoldLoad;
                    end
`else
                    queue_req = pulse_in[g];
`endif
                end
                StGap: begin
                    queue_req = pulse_in[g];
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (pend_q != '0 || pulse_in[g]) begin
                        // A pulse on the last gap cycle is served directly, freeing its own slot.
                        state_d = StHold;
                        cnt_d   = HoldLoad;
                        take    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            accept = queue_req && (pend_q != PendFull || take);
            if (queue_req && !accept) begin
                ovf_d = 1'b1;
            end
            if (accept && !take) begin
                pend_d = pend_q + 1'b1;
            end else if (take && !accept) begin
                pend_d = pend_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                pend_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                ovf_q   <= ovf_d;
            end
        end

        assign level_out[g] = (state_q == StHold);
        assign busy[g]      = (state_q != StIdle) || (pend_q != '0);
        assign overflow[g]  = ovf_q;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher (WIDTH=2, HOLD=4, GAP=2, PEND_MAX=2); expectations come
// from a window-schedule model. Honours PULSE_STRETCHER_RETRIGGER_EN the same way as the design.
module tb_pulse_stretcher;

    localparam int H    = 4;
    localparam int G    = 2;
    localparam int PMAX = 2;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] pulse_in;
    logic       ovf_clr;
    logic [1:0] level_out;
    logic [1:0] busy;
    logic [1:0] overflow;

    pulse_stretcher #(
        .WIDTH      (2),
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_MAX   (PMAX)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .ovf_clr  (ovf_clr),
        .level_out(level_out),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int arr;
        int st;
        int he;
    } win_t;

    typedef struct packed {
        logic [1:0] lvl;
        logic [1:0] bsy;
        logic [1:0] ovf;
    } exp_t;

    win_t wins[$];
    exp_t exp_q[$];
    logic [1:0] m_ovf;
    int e;
    int n_cmp;
    int n_err;
    int win_cnt;
    logic prev_lvl;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    // Each window: starts at st, high through he, low for G edges, next window no earlier than he+G+1.
    task automatic model_step(input logic [1:0] p, input logic clr, output exp_t x);
        int hold_idx;
        int last_idx;
        int pend;
        int ns;
        int d;
        bit drop;
        win_t w;
        for (int c = 0; c < 2; c++) begin
            drop = 1'b0;
            if (p[c]) begin
                hold_idx = -1;
                last_idx = -1;
                pend = 0;
                foreach (wins[i]) begin
                    if (wins[i].ch == c) begin
                        last_idx = i;
                        if (wins[i].st <= e && e <= wins[i].he) hold_idx = i;
                        if (wins[i].st > e) pend++;
                    end
                end
                if (RETRIG && hold_idx >= 0) begin
                    d = e + H - 1 - wins[hold_idx].he;
                    foreach (wins[i]) begin
                        if (wins[i].ch == c && i > hold_idx) begin
                            wins[i].st = wins[i].st + d;
                            wins[i].he = wins[i].he + d;
                        end
                    end
                    wins[hold_idx].he = wins[hold_idx].he + d;
                end else begin
                    ns = (last_idx < 0) ? e : wins[last_idx].he + G + 1;
                    if (ns < e) ns = e;
                    if (ns == e || pend < PMAX) begin
                        w.ch  = c;
                        w.arr = e;
                        w.st  = ns;
                        w.he  = ns + H - 1;
                        wins.push_back(w);
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            if (drop) m_ovf[c] = 1'b1;
            else if (clr) m_ovf[c] = 1'b0;
        end
        x.lvl = '0;
        x.bsy = '0;
        foreach (wins[i]) begin
            if (wins[i].st <= e && e <= wins[i].he) x.lvl[wins[i].ch] = 1'b1;
            if (wins[i].arr <= e && e <= wins[i].he + G) x.bsy[wins[i].ch] = 1'b1;
        end
        x.ovf = m_ovf;
    endtask

    task automatic step(input logic [1:0] p, input logic clr);
        exp_t x;
        pulse_in = p;
        ovf_clr  = clr;
        model_step(p, clr, x);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        pulse_in = '0;
        ovf_clr  = 1'b0;
        x = exp_q.pop_front();
        check_eq("level_out", 32'(level_out), 32'(x.lvl));
        check_eq("busy", 32'(busy), 32'(x.bsy));
        check_eq("overflow", 32'(overflow), 32'(x.ovf));
        if (level_out[0] && !prev_lvl) win_cnt++;
        prev_lvl = level_out[0];
        e++;
    endtask

    task automatic run_scn(input logic [63:0] m0, input logic [63:0] m1, input logic [63:0] clr,
                           input int len, input int exp_win, input string tag);
        win_cnt = 0;
        for (int k = 0; k < len; k++) begin
            step({m1[k], m0[k]}, clr[k]);
        end
        check_eq(tag, 32'(win_cnt), 32'(exp_win));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        e        = 0;
        win_cnt  = 0;
        prev_lvl = 1'b0;
        m_ovf    = '0;
        rst_n    = 1'b0;
        pulse_in = '0;
        ovf_clr  = 1'b0;

        #12;
        check_eq("rst_level", 32'(level_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        #10 rst_n = 1'b1;

        // Single pulse.
        run_scn(64'h1 << 10, 64'h0, 64'h0, 20, 1, "single_windows");
        // Three queued pulses.
        run_scn(64'h7 << 10, 64'h0, 64'h0, 32, RETRIG ? 1 : 3, "queued_windows");
        // Saturation, drop on the ovf_clr cycle (set wins), clear later.
        run_scn(64'h1F << 10, 64'h0, (64'h1 << 14) | (64'h1 << 30), 36, RETRIG ? 1 : 3,
                "ovf_windows");
        // Independent channels.
        run_scn(64'h1 << 10, 64'h1 << 12, 64'h0, 24, 1, "two_ch_windows");
        // Pulse arriving mid-window.
        run_scn((64'h1 << 10) | (64'h1 << 12), 64'h0, 64'h0, 30, RETRIG ? 1 : 2,
                "retrig_windows");

        // Reset mid-HOLD with one pulse pending.
        run_scn((64'h1 << 10) | (64'h1 << 11), 64'h0, 64'h0, 13, 1, "pre_reset_windows");
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_level", 32'(level_out), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("held_rst_level", 32'(level_out), 32'd0);
        check_eq("held_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wins.delete();
        m_ovf    = '0;
        prev_lvl = 1'b0;

        // Idle after release, then a fresh pulse.
        run_scn(64'h0, 64'h0, 64'h0, 20, 0, "post_reset_idle");
        run_scn(64'h1, 64'h0, 64'h0, 12, 1, "post_reset_windows");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
